pc_next_unit: RTL and testbench

Parametrised next-PC computation stage between Issue and IF. Accepts one control-flow operation per cycle through a valid/ready handshake, computes the sequential, branch or jump target and the link address, and holds the result in a one-entry output register. Also flags misaligned targets and keeps a saturating count of taken redirects for performance monitoring. Generalises the previous single-cycle PC adder with selectable width, compressed-instruction stepping, JAL/JALR modes and flow control.

---
 rtl/pc_next_unit.sv | 112 +++++++++++
 tb/tb_pc_next_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Next-PC stage: computes sequential, branch or jump target plus link address,
// holds it in a one-entry output register and counts taken, aligned redirects.
module pc_next_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              ALIGN_C  = 1'b1,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       mode_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             compressed_i,
  input  logic             cmp_i,
  input  logic             clr_cnt_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  pc_next_o,
  output logic [XLEN-1:0]  link_o,
  output logic             taken_o,
  output logic             misaligned_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'd0,
    MODE_BRANCH = 2'd1,
    MODE_JAL    = 2'd2,
    MODE_JALR   = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0] step;
  logic [XLEN-1:0] link_c;
  logic [XLEN-1:0] next_c;
  logic            taken_c;
  logic            mis_c;
  logic            accept;

  // Only ready_i reaches ready_o combinationally; one entry, no skid buffer.
  assign ready_o = ~valid_o | ready_i;
  assign accept  = valid_i & ready_o;

  // Target, link and alignment computation; all sums wrap modulo 2^XLEN.
  always_comb begin
    step    = compressed_i ? XLEN'(2) : XLEN'(4);
    link_c  = pc_i + step;
    next_c  = link_c;
    taken_c = 1'b0;
    mis_c   = 1'b0;
    case (mode_e'(mode_i))
      MODE_SEQ: begin
        next_c  = link_c;
        taken_c = 1'b0;
      end
      MODE_BRANCH: begin
        taken_c = cmp_i;
        next_c  = cmp_i ? (pc_i + imm_i) : link_c;
      end
      MODE_JAL: begin
        next_c  = pc_i + imm_i;
        taken_c = 1'b1;
      end
      MODE_JALR: begin
        next_c  = (rs1_i + imm_i) & ~XLEN'(1);
        taken_c = 1'b1;
      end
      default: begin
        next_c  = link_c;
        taken_c = 1'b0;
      end
    endcase
    if (ALIGN_C) mis_c = taken_c & next_c[0];
    else         mis_c = taken_c & (next_c[1:0] != 2'b00);
  end

  // Output register: load on accept, otherwise drop valid once consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      pc_next_o    <= RESET_PC;
      link_o       <= '0;
      taken_o      <= 1'b0;
      misaligned_o <= 1'b0;
    end else if (accept) begin
      valid_o      <= 1'b1;
      pc_next_o    <= next_c;
      link_o       <= link_c;
      taken_o      <= taken_c;
      misaligned_o <= mis_c;
    end else if (ready_i) begin
      valid_o      <= 1'b0;
    end
  end

  // Saturating redirect counter; clear has priority over an increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      redirect_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      redirect_cnt_o <= '0;
    end else if (accept && taken_c && !mis_c && (redirect_cnt_o != CNT_MAX)) begin
      redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: three instances (default, 4-byte alignment, 2-bit
// counter) share one stimulus stream and are checked against a reference model.
module tb_pc_next_unit;

  typedef struct {
    logic [31:0] next;
    logic [31:0] link;
    logic        taken;
    logic        mis1;
    logic        mis0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, compressed, cmp, clr_cnt, ready_i;
  logic [1:0]  mode;
  logic [31:0] pc, rs1, imm;

  logic        ready_a, valid_a, taken_a, mis_a;
  logic [31:0] next_a, link_a;
  logic [15:0] cnt_a;
  logic        ready_b, valid_b, taken_b, mis_b;
  logic [31:0] next_b, link_b;
  logic [15:0] cnt_b;
  logic        ready_c, valid_c, taken_c, mis_c;
  logic [31:0] next_c, link_c;
  logic [1:0]  cnt_c;

  exp_t sb[$];
  exp_t cur;
  logic have;
  int   ca, cb, cc;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_a),
    .mode_i(mode), .pc_i(pc), .rs1_i(rs1), .imm_i(imm),
    .compressed_i(compressed), .cmp_i(cmp), .clr_cnt_i(clr_cnt),
    .valid_o(valid_a), .ready_i(ready_i), .pc_next_o(next_a), .link_o(link_a),
    .taken_o(taken_a), .misaligned_o(mis_a), .redirect_cnt_o(cnt_a)
  );

  pc_next_unit #(.ALIGN_C(1'b0)) dut_a0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_b),
    .mode_i(mode), .pc_i(pc), .rs1_i(rs1), .imm_i(imm),
    .compressed_i(compressed), .cmp_i(cmp), .clr_cnt_i(clr_cnt),
    .valid_o(valid_b), .ready_i(ready_i), .pc_next_o(next_b), .link_o(link_b),
    .taken_o(taken_b), .misaligned_o(mis_b), .redirect_cnt_o(cnt_b)
  );

  pc_next_unit #(.CNT_W(2)) dut_c2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_c),
    .mode_i(mode), .pc_i(pc), .rs1_i(rs1), .imm_i(imm),
    .compressed_i(compressed), .cmp_i(cmp), .clr_cnt_i(clr_cnt),
    .valid_o(valid_c), .ready_i(ready_i), .pc_next_o(next_c), .link_o(link_c),
    .taken_o(taken_c), .misaligned_o(mis_c), .redirect_cnt_o(cnt_c)
  );

  function automatic exp_t model(input logic [1:0] m, input logic [31:0] p,
                                 input logic [31:0] r, input logic [31:0] i,
                                 input logic c, input logic t);
    exp_t e;
    e.link  = p + (c ? 32'd2 : 32'd4);
    e.taken = (m == 2'd1) ? t : (m >= 2'd2);
    case (m)
      2'd1:    e.next = t ? p + i : e.link;
      2'd2:    e.next = p + i;
      2'd3:    e.next = (r + i) & 32'hFFFF_FFFE;
      default: e.next = e.link;
    endcase
    e.mis1 = e.taken && e.next[0];
    e.mis0 = e.taken && (e.next[1:0] != 2'b00);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("valid_a", 32'(valid_a), 32'(have));
    chk("valid_b", 32'(valid_b), 32'(have));
    chk("valid_c", 32'(valid_c), 32'(have));
    chk("ready", 32'(ready_a), 32'(!have || ready_i));
    chk("cnt_a", 32'(cnt_a), 32'(ca));
    chk("cnt_b", 32'(cnt_b), 32'(cb));
    chk("cnt_c", 32'(cnt_c), 32'(cc));
    if (have) begin
      chk("next_a", next_a, cur.next);
      chk("link_a", link_a, cur.link);
      chk("taken_a", 32'(taken_a), 32'(cur.taken));
      chk("mis_a", 32'(mis_a), 32'(cur.mis1));
      chk("next_b", next_b, cur.next);
      chk("mis_b", 32'(mis_b), 32'(cur.mis0));
      chk("mis_c", 32'(mis_c), 32'(cur.mis1));
    end
  endtask

  // One clock: predict the handshake, push on accept, pop when the result shows.
  task automatic tick();
    logic acc, drn;
    exp_t e;
    acc = valid_i && (!have || ready_i);
    drn = have && ready_i;
    e = model(mode, pc, rs1, imm, compressed, cmp);
    if (acc) sb.push_back(e);
    if (clr_cnt) begin
      ca = 0; cb = 0; cc = 0;
    end else if (acc && e.taken) begin
      if (!e.mis1 && ca < 65535) ca++;
      if (!e.mis1 && cc < 3)     cc++;
      if (!e.mis0 && cb < 65535) cb++;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      cur  = sb.pop_front();
      have = 1'b1;
    end else if (drn) begin
      have = 1'b0;
    end
    check_all();
  endtask

  task automatic op(input logic [1:0] m, input logic [31:0] p, input logic [31:0] r,
                    input logic [31:0] i, input logic c, input logic t);
    valid_i = 1'b1; mode = m; pc = p; rs1 = r; imm = i; compressed = c; cmp = t;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; mode = 2'd0; pc = '0; rs1 = '0; imm = '0;
    compressed = 1'b0; cmp = 1'b0; clr_cnt = 1'b0; ready_i = 1'b0;
    have = 1'b0; ca = 0; cb = 0; cc = 0;
    #2;
    chk("rst_next", next_a, 32'h0);
    chk("rst_link", link_a, 32'h0);
    chk("rst_taken", 32'(taken_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;

    op(2'd0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("seq4_next", next_a, 32'h104);
    op(2'd0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("seq2_next", next_a, 32'h102);
    chk("seq2_link", link_a, 32'h102);

    op(2'd1, 32'h200, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b1);
    chk("br_taken_next", next_a, 32'h1F0);
    chk("br_taken_cnt", 32'(cnt_a), 32'd1);
    op(2'd1, 32'h200, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    chk("br_nt_next", next_a, 32'h204);

    op(2'd3, 32'h300, 32'h1001, 32'h4, 1'b0, 1'b0);
    chk("jalr_next", next_a, 32'h1004);
    chk("jalr_link", link_a, 32'h304);
    op(2'd2, 32'h400, 32'h0, 32'h3, 1'b0, 1'b0);
    chk("jal_mis", 32'(mis_a), 32'd1);
    chk("jal_mis_cnt", 32'(cnt_a), 32'd2);
    op(2'd2, 32'h100, 32'h0, 32'h2, 1'b0, 1'b0);
    chk("a0_mis_102", 32'(mis_b), 32'd1);

    op(2'd2, 32'hFFFF_FFFC, 32'h0, 32'h8, 1'b0, 1'b0);
    chk("wrap_jal", next_a, 32'h4);
    op(2'd0, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("wrap_seq", next_a, 32'h0);

    valid_i = 1'b0;
    tick();

    // Backpressure: result held for three cycles while new inputs are offered.
    ready_i = 1'b0;
    op(2'd2, 32'h500, 32'h0, 32'h10, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      op(2'd3, 32'h600 + 32'(k), 32'h2000, 32'h8, 1'b1, 1'b1);
      chk("bp_ready", 32'(ready_a), 32'd0);
      chk("bp_next", next_a, 32'h510);
    end
    ready_i = 1'b1;
    op(2'd0, 32'h700, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("bp_resume", next_a, 32'h704);
    op(2'd0, 32'h800, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("b2b", next_a, 32'h802);

    valid_i = 1'b0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int k = 0; k < 5; k++) op(2'd2, 32'h1000, 32'h0, 32'h20, 1'b0, 1'b0);
    chk("sat_cnt_c", 32'(cnt_c), 32'd3);
    chk("sat_cnt_a", 32'(cnt_a), 32'd5);
    clr_cnt = 1'b1;
    op(2'd2, 32'h1000, 32'h0, 32'h20, 1'b0, 1'b0);
    clr_cnt = 1'b0;
    chk("clr_wins", 32'(cnt_a), 32'd0);

    // Reset with a pending result drops it immediately.
    op(2'd2, 32'h1234, 32'h0, 32'h8, 1'b0, 1'b0);
    ready_i = 1'b0;
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    have = 1'b0; ca = 0; cb = 0; cc = 0;
    sb.delete();
    chk("rst_mid_next", next_a, 32'h0);
    chk("rst_mid_link", link_a, 32'h0);
    chk("rst_mid_mis", 32'(mis_a), 32'd0);
    chk("rst_mid_taken", 32'(taken_a), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    op(2'd1, 32'h40, 32'h0, 32'h10, 1'b0, 1'b1);
    chk("post_rst_next", next_a, 32'h50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
